mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined MIPS CPU. It consumes the EX/MEM pipeline register outputs, drives the data-SRAM request/handshake interface, and aligns store data with byte strobes. It sign/zero-extends load data and raises data address-error exceptions. It stalls the pipeline until the data-SRAM transaction completes and feeds the MEM/WB register.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush (exception/eret); cancels the current MEM instruction
- instr_m  in  32  instruction in MEM; opcode = instr_m[31:26]
- alu_m  in  32  effective address
- rt_m  in  32  store source data
- mem_in_exc  in  7  exception vector from EX/MEM
- wb_allow  in  1  MEM/WB accepts this cycle (pipeline advances)
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_addr  out  32  = alu_m
- data_sram_wdata  out  32  replicated store data
- data_sram_wstrb  out  4  byte enables (stores only; 0 for loads)
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  transaction complete; rdata valid for loads
- data_sram_rdata  in  32  read data
- mem_stall  out  1  hold IF..EX/MEM this cycle
- mem_load_data  out  32  extended load result
- mem_out_exc  out  7  mem_in_exc with bit4 |= AdEL, bit5 |= AdES
- mem_badvaddr  out  32  = alu_m when AdEL/AdES raised, else 0

## Operation
- Decode:
  - lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25 (loads)
  - sb 0x28, sh 0x29, sw 0x2B (stores)
  - All other opcodes are non-memory.
- Misalignment:
  - half access with alu_m[0] = 1 raises the address error.
  - word access with alu_m[1:0] != 0 raises the address error.
  - Loads raise AdEL; stores raise AdES.
- op_valid = memory op & ~flush & (mem_in_exc == 0) & no new address error.
  - An excepting instruction never issues a request.
- Store data:
  - sb: wdata = {4{rt[7:0]}}, wstrb = 1 << addr[1:0]
  - sh: wdata = {2{rt[15:0]}}, wstrb = addr[1] ? 1100 : 0011
  - sw: wdata = rt, wstrb = 1111
- Load extraction (byte b = addr[1:0], half h = addr[1]):
  - lb/lbu: byte rdata[8b+7:8b], sign/zero-extended
  - lh/lhu: half rdata[16h+15:16h], sign/zero-extended
  - lw: full word
- Data source for mem_load_data:
  - WAIT with data_ok: live rdata
  - DONE: captured rdata_q
  - otherwise: 0
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
  - IDLE:
    - Drives req = op_valid.
    - op_valid & addr_ok → WAIT.
    - op_valid & ~addr_ok → REQ.
  - REQ:
    - Holds req and all request fields stable until addr_ok.
    - addr_ok → WAIT.
    - flush → IDLE, with req dropped the same cycle.
  - WAIT:
    - req = 0.
    - data_ok & wb_allow → IDLE.
    - data_ok & ~wb_allow → DONE, capturing rdata_q.
    - flush without data_ok → CANCEL.
    - flush with data_ok → IDLE, result discarded.
  - DONE:
    - No request.
    - Output comes from rdata_q.
    - wb_allow or flush → IDLE.
  - CANCEL:
    - req = 0.
    - Waits for the orphan data_ok, discards it, then → IDLE.
- mem_stall = 1 when any of:
  - IDLE & op_valid
  - REQ
  - WAIT & ~data_ok
  - CANCEL
- Non-memory and excepting instructions pass with mem_stall = 0 and no state change.

## Timing
- Reset:
  - State IDLE, rdata_q = 0.
  - data_sram_req = 0, mem_stall = 0.
  - mem_load_data = 0, mem_out_exc = mem_in_exc.
- Request outputs are combinational from the EX/MEM inputs and state; req is never asserted in WAIT, DONE or CANCEL.
- Zero-wait SRAM (addr_ok same cycle, data_ok next cycle): 2 cycles in MEM, with mem_stall = 1 for exactly 1 cycle.
- At most one transaction is outstanding; a new request is never issued before the previous data_ok.
- Exception outputs are combinational, same cycle as instr_m.
- rst mid-transaction forces IDLE immediately; the SRAM side is reset by the same rst.

## Test plan
- sw, alu_m = 0x100, rt = 0xDEADBEEF, zero-wait SRAM:
  - req = 1, wr = 1, size = 2, wstrb = 1111, wdata = 0xDEADBEEF.
  - mem_stall high for 1 cycle.
- lb, alu_m = 0x103, rdata = 0x80112233 → mem_load_data = 0xFFFFFF80; lbu same → 0x00000080.
- lh, alu_m = 0x101:
  - req never asserted, mem_stall = 0.
  - mem_out_exc bit4 = 1, mem_badvaddr = 0x101.
  - Same for sh → bit5.
- lw with addr_ok delayed 3 cycles, then data_ok 2 cycles later:
  - req held with stable addr for 4 cycles.
  - mem_stall = 1 for 5 cycles.
  - result = rdata.
- lw, data_ok arrives while wb_allow = 0 for 2 cycles:
  - DONE holds mem_load_data = captured word with mem_stall = 0.
  - Returns to IDLE on wb_allow.
- flush in WAIT, then the next instruction is sw:
  - CANCEL until the orphan data_ok; the sw req is withheld until after it.
  - The orphan data is never presented.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-SRAM handshake and aligns store data and strobes.
// It also extends load data, flags data address errors and stalls until the SRAM transaction completes.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] instr_m,
  input  logic [31:0] alu_m,
  input  logic [31:0] rt_m,
  input  logic [6:0]  mem_in_exc,
  input  logic        wb_allow,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic [6:0]  mem_out_exc,
  output logic [31:0] mem_badvaddr
);

  // state  | meaning
  // IDLE   | no transaction; request issued combinationally for a valid op
  // REQ    | request presented, waiting for addr_ok
  // WAIT   | address accepted, waiting for data_ok
  // DONE   | data returned but MEM/WB not ready; result held in r_rdata_q
  // CANCEL | flushed while outstanding; swallow the orphan data_ok
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_rdata_q;

  logic [5:0]  w_op;
  logic        w_is_load, w_is_store, w_is_mem, w_sext;
  logic [1:0]  w_size;
  logic        w_misalign, w_adel, w_ades, w_op_valid;
  logic        w_capture;
  logic [3:0]  w_strb;
  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_op = instr_m[31:26];

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = 2'd0;
    w_sext     = 1'b0;
    case (w_op)
      6'h20: begin w_is_load  = 1'b1; w_size = 2'd0; w_sext = 1'b1; end
      6'h21: begin w_is_load  = 1'b1; w_size = 2'd1; w_sext = 1'b1; end
      6'h23: begin w_is_load  = 1'b1; w_size = 2'd2; end
      6'h24: begin w_is_load  = 1'b1; w_size = 2'd0; end
      6'h25: begin w_is_load  = 1'b1; w_size = 2'd1; end
      6'h28: begin w_is_store = 1'b1; w_size = 2'd0; end
      6'h29: begin w_is_store = 1'b1; w_size = 2'd1; end
      6'h2B: begin w_is_store = 1'b1; w_size = 2'd2; end
      default: ;
    endcase
  end

  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = ((w_size == 2'd1) & alu_m[0]) | ((w_size == 2'd2) & (alu_m[1:0] != 2'd0));
  assign w_adel     = w_is_load & w_misalign;
  assign w_ades     = w_is_store & w_misalign;
  assign w_op_valid = w_is_mem & ~flush & (mem_in_exc == 7'd0) & ~w_misalign;

  assign mem_out_exc  = mem_in_exc | {1'b0, w_ades, w_adel, 4'b0000};
  assign mem_badvaddr = (w_adel | w_ades) ? alu_m : 32'd0;

  always_comb begin
    data_sram_wdata = rt_m;
    w_strb          = 4'b1111;
    case (w_size)
      2'd0: begin
        data_sram_wdata = {4{rt_m[7:0]}};
        w_strb          = 4'b0001 << alu_m[1:0];
      end
      2'd1: begin
        data_sram_wdata = {2{rt_m[15:0]}};
        w_strb          = alu_m[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign data_sram_wr    = w_is_store;
  assign data_sram_size  = w_size;
  assign data_sram_addr  = alu_m;
  assign data_sram_wstrb = w_is_store ? w_strb : 4'b0000;

  always_comb begin
    w_next        = r_state;
    data_sram_req = 1'b0;
    mem_stall     = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        data_sram_req = w_op_valid;
        mem_stall     = w_op_valid;
        if (w_op_valid) w_next = data_sram_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        mem_stall = 1'b1;
        if (flush) begin
          w_next = S_IDLE;
        end else begin
          data_sram_req = 1'b1;
          if (data_sram_addr_ok) w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_stall = ~data_sram_data_ok;
        if (data_sram_data_ok) begin
          if (flush || wb_allow) begin
            w_next = S_IDLE;
          end else begin
            w_next    = S_DONE;
            w_capture = 1'b1;
          end
        end else if (flush) begin
          w_next = S_CANCEL;
        end
      end
      S_DONE: begin
        if (wb_allow || flush) w_next = S_IDLE;
      end
      S_CANCEL: begin
        mem_stall = 1'b1;
        if (data_sram_data_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rdata_q <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_rdata_q <= data_sram_rdata;
    end
  end

  // Orphan data in CANCEL is never presented.
  always_comb begin
    if (r_state == S_WAIT && data_sram_data_ok) w_src = data_sram_rdata;
    else if (r_state == S_DONE)                 w_src = r_rdata_q;
    else                                        w_src = 32'd0;
  end

  always_comb begin
    case (alu_m[1:0])
      2'd0:    w_byte = w_src[7:0];
      2'd1:    w_byte = w_src[15:8];
      2'd2:    w_byte = w_src[23:16];
      default: w_byte = w_src[31:24];
    endcase
    w_half = alu_m[1] ? w_src[31:16] : w_src[15:0];
    case (w_size)
      2'd0:    mem_load_data = {{24{w_sext & w_byte[7]}}, w_byte};
      2'd1:    mem_load_data = {{16{w_sext & w_half[15]}}, w_half};
      default: mem_load_data = w_src;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: store alignment, load extension, address errors,
// slow handshakes, DONE hold, REQ flush, WAIT flush with orphan data, and mid-transaction reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, flush, wb_allow;
  logic [31:0] instr_m, alu_m, rt_m;
  logic [6:0]  mem_in_exc;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_stall;
  logic [31:0] mem_load_data;
  logic [6:0]  mem_out_exc;
  logic [31:0] mem_badvaddr;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] OP_NOP = 6'h00, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                         OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29,
                         OP_SW = 6'h2B;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .instr_m(instr_m), .alu_m(alu_m), .rt_m(rt_m),
    .mem_in_exc(mem_in_exc), .wb_allow(wb_allow),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_stall(mem_stall), .mem_load_data(mem_load_data), .mem_out_exc(mem_out_exc),
    .mem_badvaddr(mem_badvaddr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
    instr_m = {op, 26'd0};
    alu_m   = addr;
    rt_m    = rt;
  endtask

  // Zero-wait load: addr_ok now, data_ok next cycle; returns the presented load data.
  task automatic zw_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd,
                         output logic [31:0] ld);
    set_op(op, addr, 32'd0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1;
    ld = mem_load_data;
    step();
    data_sram_data_ok = 1'b0;
    set_op(OP_NOP, 32'd0, 32'd0);
  endtask

  logic [31:0] ld;
  int n_req, n_stall;

  initial begin
    rst = 1'b1; flush = 1'b0; wb_allow = 1'b1; mem_in_exc = 7'h05;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    set_op(OP_NOP, 32'd0, 32'd0);
    #12;
    check_eq("rst_req", {31'd0, data_sram_req}, 32'd0);
    check_eq("rst_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("rst_ld", mem_load_data, 32'd0);
    check_eq("rst_exc", {25'd0, mem_out_exc}, 32'h05);
    rst = 1'b0; mem_in_exc = 7'd0;
    step();

    // sw zero-wait
    set_op(OP_SW, 32'h100, 32'hDEADBEEF);
    data_sram_addr_ok = 1'b1;
    #1;
    check_eq("sw_req", {31'd0, data_sram_req}, 32'd1);
    check_eq("sw_wr", {31'd0, data_sram_wr}, 32'd1);
    check_eq("sw_size", {30'd0, data_sram_size}, 32'd2);
    check_eq("sw_wstrb", {28'd0, data_sram_wstrb}, 32'hF);
    check_eq("sw_wdata", data_sram_wdata, 32'hDEADBEEF);
    check_eq("sw_addr", data_sram_addr, 32'h100);
    check_eq("sw_stall0", {31'd0, mem_stall}, 32'd1);
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    #1;
    check_eq("sw_req_wait", {31'd0, data_sram_req}, 32'd0);
    check_eq("sw_stall1", {31'd0, mem_stall}, 32'd0);
    step();
    data_sram_data_ok = 1'b0;
    set_op(OP_NOP, 32'd0, 32'd0);
    #1;
    check_eq("nop_stall", {31'd0, mem_stall}, 32'd0);

    // sub-word store alignment (checked combinationally, then completed)
    set_op(OP_SH, 32'h102, 32'h0000ABCD);
    #1;
    check_eq("sh_wdata", data_sram_wdata, 32'hABCDABCD);
    check_eq("sh_wstrb", {28'd0, data_sram_wstrb}, 32'hC);
    check_eq("sh_size", {30'd0, data_sram_size}, 32'd1);
    zw_load(OP_SH, 32'h102, 32'd0, ld);
    set_op(OP_SB, 32'h101, 32'h1234565A);
    #1;
    check_eq("sb_wdata", data_sram_wdata, 32'h5A5A5A5A);
    check_eq("sb_wstrb", {28'd0, data_sram_wstrb}, 32'h2);
    zw_load(OP_SB, 32'h101, 32'd0, ld);
    set_op(OP_LW, 32'h100, 32'd0);
    #1;
    check_eq("lw_wstrb0", {28'd0, data_sram_wstrb}, 32'h0);
    check_eq("lw_wr0", {31'd0, data_sram_wr}, 32'd0);

    // load extension
    zw_load(OP_LB,  32'h103, 32'h80112233, ld); check_eq("lb",  ld, 32'hFFFFFF80);
    zw_load(OP_LBU, 32'h103, 32'h80112233, ld); check_eq("lbu", ld, 32'h00000080);
    zw_load(OP_LB,  32'h101, 32'h80112233, ld); check_eq("lb1", ld, 32'h00000022);
    zw_load(OP_LH,  32'h102, 32'h80112233, ld); check_eq("lh",  ld, 32'hFFFF8011);
    zw_load(OP_LHU, 32'h102, 32'h80112233, ld); check_eq("lhu", ld, 32'h00008011);
    zw_load(OP_LH,  32'h100, 32'h0000F00D, ld); check_eq("lh0", ld, 32'hFFFFF00D);
    zw_load(OP_LW,  32'h104, 32'h80112233, ld); check_eq("lw",  ld, 32'h80112233);

    // address errors
    set_op(OP_LH, 32'h101, 32'd0);
    data_sram_addr_ok = 1'b1;
    #1;
    check_eq("adel_req", {31'd0, data_sram_req}, 32'd0);
    check_eq("adel_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("adel_exc", {25'd0, mem_out_exc}, 32'h10);
    check_eq("adel_bva", mem_badvaddr, 32'h101);
    step();
    check_eq("adel_req2", {31'd0, data_sram_req}, 32'd0);
    set_op(OP_SH, 32'h101, 32'd0);
    #1;
    check_eq("ades_req", {31'd0, data_sram_req}, 32'd0);
    check_eq("ades_exc", {25'd0, mem_out_exc}, 32'h20);
    check_eq("ades_bva", mem_badvaddr, 32'h101);
    set_op(OP_LW, 32'h102, 32'd0);
    #1;
    check_eq("lw_adel_exc", {25'd0, mem_out_exc}, 32'h10);
    set_op(OP_SW, 32'h200, 32'd0);
    mem_in_exc = 7'h04;
    #1;
    check_eq("inexc_req", {31'd0, data_sram_req}, 32'd0);
    check_eq("inexc_exc", {25'd0, mem_out_exc}, 32'h04);
    check_eq("inexc_bva", mem_badvaddr, 32'd0);
    step();
    mem_in_exc = 7'd0;
    data_sram_addr_ok = 1'b0;
    set_op(OP_NOP, 32'd0, 32'd0);
    step();

    // lw with addr_ok after 3 cycles and data_ok 2 cycles later
    set_op(OP_LW, 32'h200, 32'd0);
    n_req = 0; n_stall = 0;
    for (int c = 0; c < 6; c++) begin
      data_sram_addr_ok = (c == 3);
      data_sram_data_ok = (c == 5);
      data_sram_rdata   = (c == 5) ? 32'hCAFEF00D : 32'h0;
      #1;
      if (data_sram_req) begin
        n_req++;
        check_eq("slow_addr", data_sram_addr, 32'h200);
      end
      if (mem_stall) n_stall++;
      if (c == 5) check_eq("slow_data", mem_load_data, 32'hCAFEF00D);
      step();
    end
    check_eq("slow_nreq", n_req, 32'd4);
    check_eq("slow_nstall", n_stall, 32'd5);
    data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b0;
    set_op(OP_NOP, 32'd0, 32'd0);

    // DONE hold while wb_allow is low
    zw_load(OP_NOP, 32'd0, 32'd0, ld);
    set_op(OP_LW, 32'h300, 32'd0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h13572468; wb_allow = 1'b0;
    #1;
    check_eq("done_live", mem_load_data, 32'h13572468);
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("done_hold", mem_load_data, 32'h13572468);
      check_eq("done_stall", {31'd0, mem_stall}, 32'd0);
      check_eq("done_req", {31'd0, data_sram_req}, 32'd0);
      if (c == 1) wb_allow = 1'b1;
      step();
    end
    set_op(OP_NOP, 32'd0, 32'd0);
    #1;
    check_eq("done_exit_ld", mem_load_data, 32'd0);

    // flush in REQ drops req the same cycle
    set_op(OP_LW, 32'h340, 32'd0);
    step();
    flush = 1'b1;
    #1;
    check_eq("reqflush_req", {31'd0, data_sram_req}, 32'd0);
    step();
    flush = 1'b0;
    set_op(OP_NOP, 32'd0, 32'd0);
    #1;
    check_eq("reqflush_idle", {31'd0, mem_stall}, 32'd0);

    // flush in WAIT, then sw must wait for the orphan data_ok
    set_op(OP_LW, 32'h400, 32'd0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0; flush = 1'b1;
    #1;
    check_eq("wflush_stall", {31'd0, mem_stall}, 32'd1);
    step();
    flush = 1'b0;
    set_op(OP_SW, 32'h500, 32'h11223344);
    data_sram_addr_ok = 1'b1;
    #1;
    check_eq("cancel_req0", {31'd0, data_sram_req}, 32'd0);
    check_eq("cancel_stall", {31'd0, mem_stall}, 32'd1);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0BAD0;
    #1;
    check_eq("cancel_req1", {31'd0, data_sram_req}, 32'd0);
    check_eq("cancel_ld", mem_load_data, 32'd0);
    step();
    data_sram_data_ok = 1'b0;
    #1;
    check_eq("post_sw_req", {31'd0, data_sram_req}, 32'd1);
    check_eq("post_sw_wstrb", {28'd0, data_sram_wstrb}, 32'hF);
    step();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    #1;
    check_eq("post_sw_stall", {31'd0, mem_stall}, 32'd0);
    step();
    data_sram_data_ok = 1'b0;

    // reset mid-transaction
    set_op(OP_LW, 32'h600, 32'd0);
    data_sram_addr_ok = 1'b1;
    step();
    data_sram_addr_ok = 1'b0;
    set_op(OP_NOP, 32'd0, 32'd0);
    #1;
    check_eq("prerst_stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_stall", {31'd0, mem_stall}, 32'd0);
    step();
    rst = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55AA55AA;
    #1;
    check_eq("midrst_ld", mem_load_data, 32'd0);
    step();
    data_sram_data_ok = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
